// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: frame FSM encoding, parity sense constants and default widths.
// Also used by the RX side.
package uart_tx_frame_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int PRESC_W_DEF = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_frame_if.sv
// System-side handshake bundle for the UART transmitter.
// par_en/par_typ exist only when UART_TX_PARITY_EN is defined.
interface uart_tx_frame_if
    import uart_tx_frame_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) ();

    logic [PRESC_W-1:0] prescale;
    logic [DATA_W-1:0]  p_data;
    logic               data_valid;
`ifdef UART_TX_PARITY_EN
    logic               par_en;
    logic               par_typ;
`endif
    logic               ready;
    logic               busy;

`ifdef UART_TX_PARITY_EN
    modport master (output prescale, p_data, data_valid, par_en, par_typ, input ready, busy);
    modport slave  (input prescale, p_data, data_valid, par_en, par_typ, output ready, busy);
`else
    modport master (output prescale, p_data, data_valid, input ready, busy);
    modport slave  (input prescale, p_data, data_valid, output ready, busy);
`endif

endinterface

// File: rtl/uart_tx_bit_timer.sv
// Bit-period counter: counts 0..P-1 while enabled and pulses bit_done on the last count.
// A prescale of zero behaves as one cycle per bit.
module uart_tx_bit_timer #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    output logic               bit_done
);

    logic [PRESC_W-1:0] count_r;
    logic [PRESC_W-1:0] last_s;

    assign last_s   = (prescale == {PRESC_W{1'b0}}) ? {PRESC_W{1'b0}} : (prescale - PRESC_W'(1'b1));
    assign bit_done = enable && (count_r == last_s);

    // cycle counter, restarts at every bit boundary and whenever disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {PRESC_W{1'b0}};
        end else if (!enable || bit_done) begin
            count_r <= {PRESC_W{1'b0}};
        end else begin
            count_r <= count_r + PRESC_W'(1'b1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_W bits LSB first, optional parity, stop; P clk cycles per bit.
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_frame_if.slave  sys,
    output logic            tx_out
);

    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e          state_r;
    tx_state_e          next_state_s;
    tx_state_e          after_data_s;
    logic [IDX_W-1:0]   bit_idx_r;
    logic [IDX_W-1:0]   bit_idx_next_s;
    logic [DATA_W-1:0]  shadow_r;
    logic [PRESC_W-1:0] presc_r;
    logic               accept_s;
    logic               timer_en_s;
    logic               bit_done_s;
    logic               tx_next_s;
    logic               tx_r;
    logic               ready_r;
    logic               busy_r;
`ifdef UART_TX_PARITY_EN
    logic               par_en_r;
    logic               par_typ_r;

    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic typ);
        return (^data) ^ (typ == PAR_ODD);
    endfunction

    assign after_data_s = par_en_r ? ST_PARITY : ST_STOP;
`else
    assign after_data_s = ST_STOP;
`endif

    assign accept_s   = sys.data_valid & ready_r;
    assign timer_en_s = (state_r != ST_IDLE);

    uart_tx_bit_timer #(
        .PRESC_W (PRESC_W)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .enable   (timer_en_s),
        .prescale (presc_r),
        .bit_done (bit_done_s)
    );

    // state and bit index register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_idx_r <= {IDX_W{1'b0}};
        end else begin
            state_r   <= next_state_s;
            bit_idx_r <= bit_idx_next_s;
        end
    end

    // shadows hold the frame's settings so mid-frame input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r  <= {DATA_W{1'b0}};
            presc_r   <= {PRESC_W{1'b0}};
`ifdef UART_TX_PARITY_EN
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
`endif
        end else if (accept_s) begin
            shadow_r  <= sys.p_data;
            presc_r   <= sys.prescale;
`ifdef UART_TX_PARITY_EN
            par_en_r  <= sys.par_en;
            par_typ_r <= sys.par_typ;
`endif
        end
    end

    // next-state and bit index selection
    always_comb begin
        next_state_s   = state_r;
        bit_idx_next_s = bit_idx_r;
        case (state_r)
            ST_IDLE: begin
                bit_idx_next_s = {IDX_W{1'b0}};
                if (accept_s) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    next_state_s   = ST_DATA;
                    bit_idx_next_s = {IDX_W{1'b0}};
                end else begin
                    next_state_s   = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    if (bit_idx_r == LAST_IDX) begin
                        next_state_s   = after_data_s;
                        bit_idx_next_s = {IDX_W{1'b0}};
                    end else begin
                        next_state_s   = ST_DATA;
                        bit_idx_next_s = bit_idx_r + IDX_W'(1'b1);
                    end
                end else begin
                    next_state_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done_s) begin
                    next_state_s = ST_STOP;
                end else begin
                    next_state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            default: begin
                next_state_s   = ST_IDLE;
                bit_idx_next_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // line level decoded from the upcoming state so the flop lands on the bit boundary
    always_comb begin
        tx_next_s = 1'b1;
        case (next_state_s)
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shadow_r[bit_idx_next_s];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next_s = parity_bit(shadow_r, par_typ_r);
`endif
            ST_STOP:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            tx_r    <= tx_next_s;
            ready_r <= (next_state_s == ST_IDLE);
            busy_r  <= (next_state_s != ST_IDLE);
        end
    end

    assign tx_out    = tx_r;
    assign sys.ready = ready_r;
    assign sys.busy  = busy_r;

endmodule
